mem_arbiter: RTL
================

# mem_arbiter

Multi-cycle arbiter and sequencer that shares the single MMU port (SRAM, UART, LED/DPY) between the instruction-fetch requester and the data (load/store) requester. Sits between the pipeline and the MMU: latches the winning request, drives the MMU strobes for a programmed number of cycles, captures the read data and returns a one-cycle ready pulse. Also generates the pipeline stall signal while any request is outstanding.

## Interface
- RAM_WAIT, 1: cycles the MMU strobes are held for SRAM/LED/DPY accesses (≥1).
- UART_WAIT, 3: total busy cycles for UART addresses 0xBFD003F8/0xBFD003FC (≥2); strobe only in the first.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr stable until if_ready.
- if_addr  in  32  fetch address (word read, bytemode 0).
- if_rdata  out  32  fetched word, valid while if_ready.
- if_ready  out  1  one-cycle completion pulse for fetch.
- mem_req  in  1  data request; held with mem_* stable until mem_ready.
- mem_we  in  1  1 = store, 0 = load.
- mem_byte  in  1  byte access (LB/SB).
- mem_addr  in  32  data address.
- mem_wdata  in  32  store data.
- mem_rdata  out  32  load result, valid while mem_ready.
- mem_ready  out  1  one-cycle completion pulse for data.
- stall  out  1  (if_req & ~if_ready) | (mem_req & ~mem_ready).
- mmu_read  out  1  to MMU if_read.
- mmu_write  out  1  to MMU if_write.
- mmu_addr  out  32  to MMU addr.
- mmu_wdata  out  32  to MMU input_data.
- mmu_bytemode  out  1  to MMU bytemode.
- mmu_rdata  in  32  from MMU output_data.

## Operation
- States: IDLE, BUSY, DONE. Registers: state, owner (0 fetch, 1 data), cnt, latched addr/wdata/we/byte, is_uart, rdata.
- IDLE: mem_req has fixed priority over if_req. On grant latch request fields, owner, is_uart = (addr == 0xBFD003F8 || addr == 0xBFD003FC); cnt = (is_uart ? UART_WAIT : RAM_WAIT) − 1; go BUSY. No request: stay IDLE.
- BUSY: mmu_addr/wdata/bytemode from latches. RAM access: mmu_read = ~we, mmu_write = we every BUSY cycle. UART access: strobes asserted only in first BUSY cycle (one wrn/rdn pulse per access), zero in the recovery cycles. cnt decrements each cycle; when cnt == 0, rdata ← mmu_rdata (UART: captured at end of first BUSY cycle instead) and go DONE.
- Stores: rdata ← 0.
- DONE: strobes 0; owner's ready = 1, its rdata output = rdata; other ready 0. Next edge → IDLE unconditionally (requester drops or changes request in DONE).
- if_rdata/mem_rdata both reflect rdata register; only the owner's ready qualifies it.
- Reset (any state, asynchronous): state IDLE, cnt 0, all latches 0, rdata 0; all outputs 0 (mmu_* 0, readies 0); stall follows requests combinationally.

## Timing
- Request sampled in IDLE cycle k → BUSY cycles k+1..k+W → ready high in cycle k+W+1 (W = RAM_WAIT or UART_WAIT).
- Back-to-back: next grant earliest in cycle k+W+2; throughput one access per W+2 cycles.
- Simultaneous if_req and mem_req in IDLE: data granted; fetch granted at next IDLE if still requested; if_ready stays 0 meanwhile.
- Request raised while BUSY/DONE: not sampled until IDLE; no queuing.
- Request dropped mid-access: access still completes; ready pulse still issued.
- MMU strobes never asserted in IDLE or DONE; never mmu_read and mmu_write together.
- rst asserted mid-BUSY: strobes drop immediately (asynchronous); no ready pulse for aborted access.

## Test plan
- Reset: rst high during BUSY store → mmu_write, mmu_read, if_ready, mem_ready all 0 at once; after release state IDLE, no ready.
- Fetch, RAM_WAIT=1: if_req, if_addr=0x80000000, MMU returns 0x3C068000 → mmu_read high one cycle, if_ready high 2 cycles after sampling, if_rdata=0x3C068000.
- Conflict: if_req and mem_req (load 0x80400010) in same cycle → data served first, mem_ready; fetch follows, if_ready 3 cycles later; stall high throughout until if_ready.
- UART write: mem_we=1, mem_addr=0xBFD003F8, wdata=0x41, UART_WAIT=3 → mmu_write high exactly one cycle, then 2 idle cycles, mem_ready in 4th cycle after sampling.
- Byte store: mem_byte=1, addr=0x80000003, wdata=0x000000AB → mmu_bytemode=1, mmu_addr=0x80000003, mmu_wdata=0xAB for RAM_WAIT cycles; mem_rdata=0 at ready.
- Dropped request: mem_req deasserted in first BUSY cycle → access completes, mem_ready still pulses once, arbiter returns to IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing the single MMU port between instruction fetch and data access.
// Data requests win over fetch; each access holds the MMU strobes for a fixed wait, then pulses ready.
module mem_arbiter #(
    parameter int RAM_WAIT  = 1,
    parameter int UART_WAIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic        mem_byte,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        stall,
    output logic        mmu_read,
    output logic        mmu_write,
    output logic [31:0] mmu_addr,
    output logic [31:0] mmu_wdata,
    output logic        mmu_bytemode,
    input  logic [31:0] mmu_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [31:0] UART_DATA_ADDR = 32'hBFD0_03F8;
    localparam logic [31:0] UART_STAT_ADDR = 32'hBFD0_03FC;
    localparam logic [7:0]  RAM_CNT        = 8'(RAM_WAIT - 1);
    localparam logic [7:0]  UART_CNT       = 8'(UART_WAIT - 1);

    state_t      state;
    logic        owner;
    logic [7:0]  cnt;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_we;
    logic        lat_byte;
    logic        is_uart;
    logic [31:0] rdata;

    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic        req_byte;
    logic        req_uart;
    logic        capture;

    always_comb begin
        req_addr  = if_addr;
        req_wdata = 32'h0;
        req_we    = 1'b0;
        req_byte  = 1'b0;
        if (mem_req) begin
            req_addr  = mem_addr;
            req_wdata = mem_wdata;
            req_we    = mem_we;
            req_byte  = mem_byte;
        end
        req_uart = (req_addr == UART_DATA_ADDR) || (req_addr == UART_STAT_ADDR);
        // UART data is sampled while its single strobe is active; RAM data at the end of the hold
        capture  = is_uart ? (cnt == UART_CNT) : (cnt == 8'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            cnt       <= 8'd0;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
            lat_we    <= 1'b0;
            lat_byte  <= 1'b0;
            is_uart   <= 1'b0;
            rdata     <= 32'h0;
            mmu_read  <= 1'b0;
            mmu_write <= 1'b0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mmu_read  <= 1'b0;
                    mmu_write <= 1'b0;
                    if_ready  <= 1'b0;
                    mem_ready <= 1'b0;
                    if (mem_req || if_req) begin
                        owner     <= mem_req;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_we    <= req_we;
                        lat_byte  <= req_byte;
                        is_uart   <= req_uart;
                        cnt       <= req_uart ? UART_CNT : RAM_CNT;
                        mmu_read  <= ~req_we;
                        mmu_write <= req_we;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (capture)
                        rdata <= lat_we ? 32'h0 : mmu_rdata;
                    if (cnt == 8'd0) begin
                        mmu_read  <= 1'b0;
                        mmu_write <= 1'b0;
                        if_ready  <= ~owner;
                        mem_ready <= owner;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - 8'd1;
                        // UART gets one strobe pulse, then recovery cycles with strobes low
                        if (is_uart) begin
                            mmu_read  <= 1'b0;
                            mmu_write <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if_ready  <= 1'b0;
                    mem_ready <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    mmu_read  <= 1'b0;
                    mmu_write <= 1'b0;
                    if_ready  <= 1'b0;
                    mem_ready <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign mmu_addr     = lat_addr;
    assign mmu_wdata    = lat_wdata;
    assign mmu_bytemode = lat_byte;
    assign if_rdata     = rdata;
    assign mem_rdata    = rdata;
    assign stall        = (if_req & ~if_ready) | (mem_req & ~mem_ready);

endmodule
